// File: rtl/rp_8bit_pkg.sv
// Shared types for the 8-bit data-bus arbiter slice: owner state encoding and
// the default data-bus address width.
package rp_8bit_pkg;

  localparam int unsigned DAW_DEFAULT = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } owner_e;

endpackage

// File: rtl/rp_8bit_bd_arb.sv
// Two-master (m0 = CPU, m1 = DMA/debug) arbiter for a single-port 8-bit memory.
// Optional m1 bus lock is compiled in with RP_BD_ARB_LOCK_EN.
module rp_8bit_bd_arb
  import rp_8bit_pkg::*;
#(
  parameter int unsigned DAW = DAW_DEFAULT,
  parameter int unsigned MLK = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           m0_req,
  input  logic           m0_wen,
  input  logic [DAW-1:0] m0_adr,
  input  logic [7:0]     m0_wdt,
  output logic [7:0]     m0_rdt,
  output logic           m0_ack,
  input  logic           m1_req,
  input  logic           m1_wen,
  input  logic [DAW-1:0] m1_adr,
  input  logic [7:0]     m1_wdt,
`ifdef RP_BD_ARB_LOCK_EN
  input  logic           m1_lck,
`endif
  output logic [7:0]     m1_rdt,
  output logic           m1_ack,
  output logic           mem_ena,
  output logic           mem_wen,
  output logic [DAW-1:0] mem_adr,
  output logic [7:0]     mem_wdt,
  input  logic [7:0]     mem_rdt
);

  if (MLK < 1 || MLK > 255) begin : g_mlk_range
    $error("rp_8bit_bd_arb: MLK must be in 1..255");
  end

  owner_e state_r;
  owner_e state_nxt_s;
  logic   wen_last_r;
  logic   m0_elig_s;
  logic   m1_elig_s;
  logic   gnt0_s;
  logic   gnt1_s;

  // Acks decode the last-cycle grant; masking with rst drops an ack whose access straddles reset entry.
  assign m0_ack = (state_r == G0) & rst;
  assign m1_ack = (state_r == G1) & rst;
  assign m0_rdt = (m0_ack && !wen_last_r) ? mem_rdt : 8'h00;
  assign m1_rdt = (m1_ack && !wen_last_r) ? mem_rdt : 8'h00;

`ifdef RP_BD_ARB_LOCK_EN
  localparam logic [7:0] MLK_C = 8'(MLK);

  logic       lock_r;
  logic       block_r;
  logic [7:0] cnt_r;
  logic [7:0] cnt_inc_s;
  logic       block_eff_s;

  // The m0 grant owed after a forced release has completed once m0 acks.
  assign block_eff_s = block_r & ~m0_ack;
  assign cnt_inc_s   = (lock_r ? cnt_r : 8'd0) + 8'd1;
  assign m0_elig_s   = rst & m0_req & ~m0_ack & ~lock_r;

  // Lock state: set by a locked m1 grant, released by m1_lck=0 or after MLK grants.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lock_r  <= 1'b0;
      block_r <= 1'b0;
      cnt_r   <= 8'd0;
    end else begin
      block_r <= block_eff_s;
      if (!m1_lck) begin
        lock_r <= 1'b0;
        cnt_r  <= 8'd0;
      end else if (gnt1_s && !block_eff_s) begin
        if (cnt_inc_s >= MLK_C) begin
          lock_r  <= 1'b0;
          cnt_r   <= 8'd0;
          block_r <= 1'b1;
        end else begin
          lock_r <= 1'b1;
          cnt_r  <= cnt_inc_s;
        end
      end else begin
        lock_r <= lock_r;
        cnt_r  <= cnt_r;
      end
    end
  end
`else
  assign m0_elig_s = rst & m0_req & ~m0_ack;
`endif

  assign m1_elig_s = rst & m1_req & ~m1_ack;
  assign gnt0_s    = m0_elig_s;
  assign gnt1_s    = m1_elig_s & ~m0_elig_s;

  // Owner state register: remembers who was granted last cycle and whether it wrote.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= IDLE;
      wen_last_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wen_last_r <= mem_wen;
    end
  end

  // Next owner is simply this cycle's winner.
  always_comb begin
    state_nxt_s = IDLE;
    if (gnt0_s) begin
      state_nxt_s = G0;
    end else if (gnt1_s) begin
      state_nxt_s = G1;
    end else begin
      state_nxt_s = IDLE;
    end
  end

  // Memory port muxes the winner's request straight through.
  always_comb begin
    mem_ena = 1'b0;
    mem_wen = 1'b0;
    mem_adr = '0;
    mem_wdt = 8'h00;
    if (gnt0_s) begin
      mem_ena = 1'b1;
      mem_wen = m0_wen;
      mem_adr = m0_adr;
      mem_wdt = m0_wdt;
    end else if (gnt1_s) begin
      mem_ena = 1'b1;
      mem_wen = m1_wen;
      mem_adr = m1_adr;
      mem_wdt = m1_wdt;
    end else begin
      mem_ena = 1'b0;
    end
  end

endmodule
